data_select_ctrl: RTL and testbench

Initiator for the registered signed select/arithmetic unit: accepts one operand pair over a valid/ready handshake, drives the unit's `a`/`b`/`select` inputs through all four operation codes on consecutive cycles, and captures the unit's 9-bit result after its fixed response latency. The four results are returned as one packed bundle on a valid/ready output. The block sits between the operand source and the arithmetic unit; the unit has no handshake of its own, so this controller tracks result alignment with an internal tag delay line.

---
 rtl/data_select_pkg.sv | 48 ++++
 rtl/data_select_tag_pipe.sv | 30 +++
 rtl/data_select_ctrl.sv | 121 ++++++++++++
 tb/tb_data_select_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_select_pkg.sv
// Shared types and constants for the data_select controller: select codes,
// controller states, result/bundle geometry and the saturation helpers.
package data_select_pkg;

  localparam int DATA_W    = 8;
  localparam int RES_W     = 9;
  localparam int NUM_SLOTS = 4;
  localparam int BUNDLE_W  = NUM_SLOTS * RES_W;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A   = 2'b00;
  localparam sel_t SEL_B   = 2'b01;
  localparam sel_t SEL_ADD = 2'b10;
  localparam sel_t SEL_SUB = 2'b11;

  // Bundle slot index equals the select code that produced it.
  localparam int SLOT_A   = 0;
  localparam int SLOT_B   = 1;
  localparam int SLOT_ADD = 2;
  localparam int SLOT_SUB = 3;

  localparam logic [RES_W-1:0] SAT_MAX = 9'h07F;
  localparam logic [RES_W-1:0] SAT_MIN = 9'h180;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic valid;
    sel_t tag;
  } tag_t;

  // A 9-bit value fits in 8 signed bits only when its top two bits agree.
  function automatic logic out_of_range(input logic [RES_W-1:0] c);
    return c[RES_W-1] != c[RES_W-2];
  endfunction

  function automatic logic [RES_W-1:0] clamp(input logic [RES_W-1:0] c);
    if (!out_of_range(c)) return c;
    return c[RES_W-1] ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/data_select_tag_pipe.sv
// DEPTH-stage shift of {valid, tag} that marks which select code the
// arithmetic unit's current result belongs to.
module data_select_tag_pipe
  import data_select_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t in_tag,
  output tag_t out_tag
);

  tag_t stage [DEPTH];

  // NOTE: every stage is reset, not just valid bits: a reset must flush
  // in-flight tags so no stale capture can follow it.
  // NOTE: non-blocking assignments so each stage takes its neighbour's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_tag = stage[DEPTH-1];

endmodule

// File: rtl/data_select_ctrl.sv
// Initiator for the registered select/arithmetic unit: issues all four codes for
// one operand pair and returns the four results as one bundle.
// Optional clamping of results to 8-bit signed range: DATA_SELECT_CTRL_SAT_EN.
module data_select_ctrl
  import data_select_pkg::*;
#(
  parameter int RESP_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic [DATA_W-1:0]   a_o,
  output logic [DATA_W-1:0]   b_o,
  output logic [1:0]          select_o,
  input  logic [RES_W-1:0]    c_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BUNDLE_W-1:0] out_res,
  output logic                out_ovf
);

  state_t state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q;
  sel_t              sel_q;
  logic [NUM_SLOTS-1:0][RES_W-1:0] res_q;

  tag_t       issue_tag, exit_tag;
  logic       accept, capture;
  logic [RES_W-1:0] cap_val;

  // The select register doubles as the issue counter.
  assign issue_tag.valid = (state_q == ST_ISSUE);
  assign issue_tag.tag   = sel_q;

  data_select_tag_pipe #(.DEPTH(RESP_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_tag  (issue_tag),
    .out_tag (exit_tag)
  );

  // NOTE: defaults first so no path through the case leaves a signal unassigned.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        capture = exit_tag.valid;
        if (sel_q == SEL_SUB) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        capture = exit_tag.valid;
        if (exit_tag.valid && exit_tag.tag == SEL_SUB) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DATA_SELECT_CTRL_SAT_EN
  logic ovf_q;
  assign cap_val = clamp(c_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (capture && out_of_range(c_i)) begin
      ovf_q <= 1'b1;
    end
  end

  assign out_ovf = ovf_q;
`else
  assign cap_val = c_i;
  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= SEL_A;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        sel_q <= SEL_A;
        res_q <= '0;
      end else if (state_q == ST_ISSUE && sel_q != SEL_SUB) begin
        sel_q <= sel_q + 2'd1;
      end
      if (capture) res_q[exit_tag.tag] <= cap_val;
    end
  end

  // in_ready is forced low while reset is asserted, not just after it.
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign a_o       = a_q;
  assign b_o       = b_q;
  assign select_o  = sel_q;
  assign out_res   = res_q;

endmodule

// File: tb/tb_data_select_ctrl.sv
// Scoreboard bench for data_select_ctrl: two instances (RESP_LAT 1 and 3), each
// with a behavioural arithmetic unit; expected bundles come from plain arithmetic.
module tb_data_select_ctrl;

  typedef struct {
    logic [35:0] res;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_a      [2];
  logic [7:0]  in_b      [2];
  logic [7:0]  a_o       [2];
  logic [7:0]  b_o       [2];
  logic [1:0]  sel       [2];
  logic [8:0]  c_i       [2];
  logic [8:0]  rand_c    [2];
  logic        rand_mode [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [35:0] out_res   [2];
  logic        out_ovf   [2];

  exp_t sb_q [2][$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  // Reference: the four results are A, B, A+B, A-B as integers, clamped when enabled.
  function automatic exp_t model(input logic signed [7:0] a, input logic signed [7:0] b,
                                 input int lat, input int acc);
    exp_t e;
    int   r [4];
    r[0] = int'(a);
    r[1] = int'(b);
    r[2] = int'(a) + int'(b);
    r[3] = int'(a) - int'(b);
    e.ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef DATA_SELECT_CTRL_SAT_EN
      if (r[k] > 127) begin
        r[k] = 127;
        e.ovf = 1'b1;
      end else if (r[k] < -128) begin
        r[k] = -128;
        e.ovf = 1'b1;
      end
`endif
      e.res[k*9 +: 9] = r[k][8:0];
    end
    e.lat = 5 + lat;
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [8:0] unit_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] s);
    logic [8:0] sa, sb;
    sa = {a[7], a};
    sb = {b[7], b};
    case (s)
      2'b00:   return sa;
      2'b01:   return sb;
      2'b10:   return sa + sb;
      default: return sa - sb;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    data_select_ctrl #(.RESP_LAT(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_a      (in_a[g]),
      .in_b      (in_b[g]),
      .a_o       (a_o[g]),
      .b_o       (b_o[g]),
      .select_o  (sel[g]),
      .c_i       (c_i[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_res   (out_res[g]),
      .out_ovf   (out_ovf[g])
    );

    // Registered arithmetic unit with LAT cycles from select to result.
    logic [8:0] pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= unit_fn(a_o[g], b_o[g], sel[g]);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign c_i[g] = rand_mode[g] ? rand_c[g] : pipe[LAT-1];

    logic prev_v = 1'b0;
    exp_t e;
    always @(negedge clk) begin
      if (!rst_n[g]) begin
        prev_v <= 1'b0;
      end else begin
        if (out_valid[g] && !prev_v) begin
          check($sformatf("lane%0d bundle expected", g), 64'(sb_q[g].size() != 0), 64'(1));
          if (sb_q[g].size() != 0) begin
            e = sb_q[g].pop_front();
            check($sformatf("lane%0d out_res", g), 64'(out_res[g]), 64'(e.res));
            check($sformatf("lane%0d out_ovf", g), 64'(out_ovf[g]), 64'(e.ovf));
            check($sformatf("lane%0d latency", g), 64'(cyc - e.acc), 64'(e.lat));
          end
        end
        prev_v <= out_valid[g];
      end
    end
  end

  task automatic send(input int l, input logic [7:0] a, input logic [7:0] b);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      in_valid[l] = 1'b1;
      in_a[l] = a;
      in_b[l] = b;
      if (in_ready[l]) begin
        sb_q[l].push_back(model(a, b, lat_of(l), cyc));
        done = 1'b1;
      end
    end
    @(negedge clk);
    in_valid[l] = 1'b0;
    in_a[l] = 8'($urandom);
    in_b[l] = 8'($urandom);
    check($sformatf("lane%0d accept", l), 64'(done), 64'(1));
  endtask

  task automatic wait_valid(input int l);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid[l]) seen = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("lane%0d out_valid seen", l), 64'(seen), 64'(1));
  endtask

  task automatic wait_done(input int l);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      out_ready[l] = ($urandom_range(0, 3) != 0);
      if (out_valid[l] && out_ready[l]) begin
        @(negedge clk);
        done = 1'b1;
      end
    end
    out_ready[l] = 1'b1;
    check($sformatf("lane%0d transfer", l), 64'(done), 64'(1));
  endtask

  task automatic check_zero(input int l, input string tag);
    check($sformatf("lane%0d %s in_ready", l, tag), 64'(in_ready[l]), 64'(0));
    check($sformatf("lane%0d %s out_valid", l, tag), 64'(out_valid[l]), 64'(0));
    check($sformatf("lane%0d %s a_o/b_o/sel", l, tag), 64'({a_o[l], b_o[l], sel[l]}), 64'(0));
    check($sformatf("lane%0d %s out_res", l, tag), 64'(out_res[l]), 64'(0));
    check($sformatf("lane%0d %s out_ovf", l, tag), 64'(out_ovf[l]), 64'(0));
  endtask

  // Directed pair with out_ready high: checks sub slot, ovf and one-cycle transfer.
  task automatic directed(input int l, input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] exp_sub, input logic exp_ovf);
    send(l, a, b);
    wait_valid(l);
    check($sformatf("lane%0d sub slot", l), 64'(out_res[l][35:27]), 64'(exp_sub));
    check($sformatf("lane%0d ovf flag", l), 64'(out_ovf[l]), 64'(exp_ovf));
    @(negedge clk);
    check($sformatf("lane%0d drop after transfer", l), 64'(out_valid[l]), 64'(0));
    check($sformatf("lane%0d ready after transfer", l), 64'(in_ready[l]), 64'(1));
  endtask

  task automatic backpressure(input int l);
    logic [7:0] a, b;
    exp_t e;
    a = 8'($urandom);
    b = 8'($urandom);
    e = model(a, b, lat_of(l), 0);
    out_ready[l] = 1'b0;
    send(l, a, b);
    wait_valid(l);
    rand_mode[l] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_c[l]   = 9'($urandom);
      in_valid[l] = 1'b1;
      in_a[l]     = 8'($urandom);
      in_b[l]     = 8'($urandom);
      @(negedge clk);
      check($sformatf("lane%0d held res", l), 64'(out_res[l]), 64'(e.res));
      check($sformatf("lane%0d held in_ready", l), 64'(in_ready[l]), 64'(0));
      check($sformatf("lane%0d held valid", l), 64'(out_valid[l]), 64'(1));
    end
    in_valid[l]  = 1'b0;
    rand_mode[l] = 1'b0;
    out_ready[l] = 1'b1;
    @(negedge clk);
    check($sformatf("lane%0d bp transfer", l), 64'(out_valid[l]), 64'(0));
    check($sformatf("lane%0d bp idle", l), 64'(in_ready[l]), 64'(1));
  endtask

  task automatic reset_mid(input int l);
    send(l, 8'($urandom), 8'($urandom));
    @(negedge clk);
    #2 rst_n[l] = 1'b0;
    #1 check_zero(l, "mid-reset");
    void'(sb_q[l].pop_back());
    @(negedge clk);
    rst_n[l] = 1'b1;
    send(l, 8'd1, 8'd1);
    wait_valid(l);
    check($sformatf("lane%0d post-reset bundle", l), 64'(out_res[l]),
          64'({9'h000, 9'h002, 9'h001, 9'h001}));
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int l = 0; l < 2; l++) begin
      rst_n[l] = 1'b0;
      in_valid[l] = 1'b0;
      in_a[l] = '0;
      in_b[l] = '0;
      out_ready[l] = 1'b1;
      rand_mode[l] = 1'b0;
      rand_c[l] = '0;
    end
    repeat (2) @(negedge clk);
    for (int l = 0; l < 2; l++) check_zero(l, "reset");
    for (int l = 0; l < 2; l++) rst_n[l] = 1'b1;
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("lane%0d idle in_ready", l), 64'(in_ready[l]), 64'(1));
      check($sformatf("lane%0d idle out_valid", l), 64'(out_valid[l]), 64'(0));
      check($sformatf("lane%0d idle out_res", l), 64'(out_res[l]), 64'(0));
    end

    for (int l = 0; l < 2; l++) begin
      send(l, 8'd5, 8'd3);
      wait_valid(l);
      check($sformatf("lane%0d 5,3 bundle", l), 64'(out_res[l]),
            64'({9'h002, 9'h008, 9'h003, 9'h005}));
      @(negedge clk);
`ifdef DATA_SELECT_CTRL_SAT_EN
      directed(l, 8'h80, 8'h7F, 9'h180, 1'b1);
      directed(l, 8'd100, 8'h9C, 9'h07F, 1'b1);
`else
      directed(l, 8'h80, 8'h7F, 9'h101, 1'b0);
      directed(l, 8'd100, 8'h9C, 9'h0C8, 1'b0);
`endif
      backpressure(l);
      reset_mid(l);
      for (int i = 0; i < 15; i++) begin
        send(l, 8'($urandom), 8'($urandom));
        wait_done(l);
      end
      repeat (2) @(negedge clk);
      check($sformatf("lane%0d scoreboard drained", l), 64'(sb_q[l].size()), 64'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
